// File: rtl/assoc_cache_lru_wb.sv
// Fully associative write-back cache, one word per line, true-LRU replacement.
// CPU side uses a valid/ready request with a one-cycle response strobe; the
// RAM side uses req/ack. Misses write back a dirty victim, idle one cycle,
// then fill. Writes allocate on miss.
module assoc_cache_lru_wb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int WAYS   = 4,
    parameter int STAT_W = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_wren,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [DATA_W-1:0]              req_data,
    output logic                           rsp_valid,
    output logic [DATA_W-1:0]              rsp_data,
    output logic                           rsp_hit,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic                           mem_ack,
    input  logic [DATA_W-1:0]              mem_rdata,
    output logic [WAYS-1:0]                valid_vec,
    output logic [WAYS-1:0]                dirty_vec,
    output logic [WAYS*$clog2(WAYS)-1:0]   age_vec,
    output logic [STAT_W-1:0]              hit_cnt,
    output logic [STAT_W-1:0]              miss_cnt
);

    localparam int AGE_W = $clog2(WAYS);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, GAP, FILL, RESP} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   tag_mem  [WAYS];
    logic [DATA_W-1:0]   data_mem [WAYS];
    logic [AGE_W-1:0]    age      [WAYS];
    logic                wren_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [AGE_W-1:0]    way_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_hit_q;
    logic                hit;
    logic                have_invalid;
    logic [AGE_W-1:0]    hit_way;
    logic [AGE_W-1:0]    victim_way;

    // Tag match and victim selection for the latched address.
    always_comb begin
        hit          = 1'b0;
        hit_way      = '0;
        have_invalid = 1'b0;
        victim_way   = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (valid_vec[i] && tag_mem[i] == addr_q) begin
                hit     = 1'b1;
                hit_way = AGE_W'(i);
            end
        end
        // Scan downwards so the lowest-index invalid way is the one kept.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                have_invalid = 1'b1;
                victim_way   = AGE_W'(i);
            end
        end
        if (!have_invalid) begin
            for (int i = 0; i < WAYS; i++) begin
                if (age[i] == AGE_W'(WAYS - 1)) victim_way = AGE_W'(i);
            end
        end
    end

    // Next-state and port drive; memory-side outputs are decoded from state so
    // an asynchronous reset drops mem_req at once.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_hit   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (hit)                                          state_nxt = RESP;
                else if (valid_vec[victim_way] && dirty_vec[victim_way]) state_nxt = WB;
                else                                              state_nxt = FILL;
            end
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = tag_mem[way_q];
                mem_wdata = data_mem[way_q];
                if (mem_ack) state_nxt = GAP;
            end
            GAP: state_nxt = FILL;
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = rsp_data_q;
                rsp_hit   = rsp_hit_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, request latch, line status, LRU ages and counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state      <= IDLE;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            way_q      <= '0;
            rsp_data_q <= '0;
            rsp_hit_q  <= 1'b0;
            valid_vec  <= '0;
            dirty_vec  <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            for (int i = 0; i < WAYS; i++) age[i] <= AGE_W'(i);
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wren_q <= req_wren;
                        addr_q <= req_addr;
                        data_q <= req_data;
                    end
                end
                LOOKUP: begin
                    rsp_hit_q <= hit;
                    if (hit) begin
                        way_q      <= hit_way;
                        rsp_data_q <= wren_q ? data_q : data_mem[hit_way];
                        if (wren_q) dirty_vec[hit_way] <= 1'b1;
                    end else begin
                        way_q <= victim_way;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid_vec[way_q] <= 1'b1;
                        dirty_vec[way_q] <= wren_q;
                        rsp_data_q       <= wren_q ? data_q : mem_rdata;
                    end
                end
                RESP: begin
                    for (int i = 0; i < WAYS; i++) begin
                        if (AGE_W'(i) == way_q)      age[i] <= '0;
                        else if (age[i] < age[way_q]) age[i] <= age[i] + 1'b1;
                    end
                    if (rsp_hit_q) begin
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                    end else begin
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: written on a write hit or on fill completion.
    // NOTE: the arrays carry no reset; valid_vec alone says which lines mean anything.
    always_ff @(posedge clock) begin
        if (state == LOOKUP && hit && wren_q) data_mem[hit_way] <= data_q;
        if (state == FILL && mem_ack) begin
            tag_mem[way_q]  <= addr_q;
            data_mem[way_q] <= wren_q ? data_q : mem_rdata;
        end
    end

    // Flatten the per-way ages onto the status port.
    always_comb begin
        age_vec = '0;
        for (int i = 0; i < WAYS; i++) age_vec[i*AGE_W +: AGE_W] = age[i];
    end

endmodule

// File: tb/tb_assoc_cache_lru_wb.sv
// Self-checking bench for assoc_cache_lru_wb: directed scenarios followed by
// random traffic, compared against a recency-list model of the cache and RAM.
module tb_assoc_cache_lru_wb;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int WAYS   = 4;
    localparam int AGE_W  = 2;
    localparam int STAT_W = 16;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    req_valid, req_ready, req_wren;
    logic [ADDR_W-1:0]       req_addr;
    logic [DATA_W-1:0]       req_data;
    logic                    rsp_valid, rsp_hit;
    logic [DATA_W-1:0]       rsp_data;
    logic                    mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata, mem_rdata;
    logic [WAYS-1:0]         valid_vec, dirty_vec;
    logic [WAYS*AGE_W-1:0]   age_vec;
    logic [STAT_W-1:0]       hit_cnt, miss_cnt;

    assoc_cache_lru_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .STAT_W(STAT_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wren(req_wren),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .valid_vec(valid_vec), .dirty_vec(dirty_vec), .age_vec(age_vec),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: lines, recency list (front = most recent), RAM image.
    logic              m_valid [WAYS];
    logic              m_dirty [WAYS];
    logic [ADDR_W-1:0] m_tag   [WAYS];
    logic [DATA_W-1:0] m_data  [WAYS];
    logic [DATA_W-1:0] ram     [1<<ADDR_W];
    int                lru[$];
    int                m_hits, m_misses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        lru.delete();
        for (int i = 0; i < WAYS; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            lru.push_back(i);
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic check_status(input string tag);
        logic [WAYS-1:0]       ev, ed;
        logic [WAYS*AGE_W-1:0] ea;
        ea = '0;
        for (int i = 0; i < WAYS; i++) begin
            ev[i] = m_valid[i];
            ed[i] = m_dirty[i];
        end
        for (int i = 0; i < lru.size(); i++) ea[lru[i]*AGE_W +: AGE_W] = AGE_W'(i);
        check({tag, "_valid"}, 32'(valid_vec), 32'(ev));
        check({tag, "_dirty"}, 32'(dirty_vec), 32'(ed));
        check({tag, "_age"},   32'(age_vec),   32'(ea));
        check({tag, "_hits"},  32'(hit_cnt),   32'(m_hits));
        check({tag, "_miss"},  32'(miss_cnt),  32'(m_misses));
    endtask

    // One request from acceptance to return-to-idle. Entered and left on a negedge.
    task automatic run_txn(input string tag, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input int delay);
        int                way, exp_hit, exp_wb;
        logic [ADDR_W-1:0] wb_addr;
        logic [DATA_W-1:0] wb_data, exp_data;
        int                got_rsp, rsp_n, last_ack, wb_n, req_cyc, acc_cnt;
        logic              gap_req, obs_hit;
        logic [DATA_W-1:0] obs_data;
        logic              acc_we    [4];
        logic [ADDR_W-1:0] acc_addr  [4];
        logic [DATA_W-1:0] acc_wdata [4];
        logic [ADDR_W-1:0] first_addr;
        logic [DATA_W-1:0] first_wdata;

        // Prediction.
        way = -1; exp_wb = 0; wb_addr = '0; wb_data = '0;
        for (int i = 0; i < WAYS; i++) if (m_valid[i] && m_tag[i] == a) way = i;
        exp_hit = (way >= 0);
        if (exp_hit) begin
            if (wr) begin
                m_data[way]  = d;
                m_dirty[way] = 1'b1;
            end
            if (m_hits < 65535) m_hits++;
        end else begin
            for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[i]) way = i;
            if (way < 0) way = lru[WAYS-1];
            exp_wb  = m_valid[way] && m_dirty[way];
            wb_addr = m_tag[way];
            wb_data = m_data[way];
            if (exp_wb) ram[wb_addr] = wb_data;
            m_tag[way]   = a;
            m_valid[way] = 1'b1;
            m_dirty[way] = wr;
            m_data[way]  = wr ? d : ram[a];
            if (m_misses < 65535) m_misses++;
        end
        exp_data = m_data[way];
        for (int i = 0; i < lru.size(); i++) if (lru[i] == way) begin lru.delete(i); break; end
        lru.push_front(way);

        // Drive the request.
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_wren = wr; req_addr = a; req_data = d;
        @(negedge clock);
        req_valid = 1'b0;

        got_rsp = 0; rsp_n = 0; last_ack = -10; wb_n = -10; req_cyc = 0; acc_cnt = 0;
        gap_req = 1'b1; obs_hit = 1'b0; obs_data = '0; first_addr = '0; first_wdata = '0;
        for (int n = 1; n <= 60 && got_rsp == 0; n++) begin
            if (n > 1) @(negedge clock);
            mem_ack = 1'b0;
            if (n == wb_n + 1) gap_req = mem_req;
            if (rsp_valid) begin
                got_rsp = 1; rsp_n = n; obs_data = rsp_data; obs_hit = rsp_hit;
            end else if (mem_req) begin
                if (req_cyc == 0) begin
                    first_addr  = mem_addr;
                    first_wdata = mem_wdata;
                end
                req_cyc++;
                if (req_cyc > delay) begin
                    check({tag, "_mem_addr_stable"}, 32'(mem_addr), 32'(first_addr));
                    if (mem_we) check({tag, "_mem_wdata_stable"}, 32'(mem_wdata), 32'(first_wdata));
                    if (acc_cnt < 4) begin
                        acc_we[acc_cnt] = mem_we; acc_addr[acc_cnt] = mem_addr; acc_wdata[acc_cnt] = mem_wdata;
                    end
                    acc_cnt++;
                    mem_rdata = ram[mem_addr];
                    mem_ack   = 1'b1;
                    if (mem_we) wb_n = n;
                    last_ack = n;
                    req_cyc  = 0;
                end
            end
        end
        check({tag, "_rsp_seen"}, 32'(got_rsp), 32'd1);
        if (got_rsp == 0) return;

        check({tag, "_rsp_data"}, 32'(obs_data), 32'(exp_data));
        check({tag, "_rsp_hit"},  32'(obs_hit),  32'(exp_hit));
        check({tag, "_latency"},  32'(rsp_n),    32'(exp_hit ? 2 : last_ack + 1));
        check({tag, "_mem_accesses"}, 32'(acc_cnt), 32'(exp_hit ? 0 : (exp_wb ? 2 : 1)));
        if (!exp_hit && acc_cnt == (exp_wb ? 2 : 1)) begin
            if (exp_wb) begin
                check({tag, "_wb_we"},    32'(acc_we[0]),    32'd1);
                check({tag, "_wb_addr"},  32'(acc_addr[0]),  32'(wb_addr));
                check({tag, "_wb_wdata"}, 32'(acc_wdata[0]), 32'(wb_data));
                check({tag, "_gap"},      32'(gap_req),      32'd0);
            end
            check({tag, "_fill_we"},   32'(acc_we[acc_cnt-1]),   32'd0);
            check({tag, "_fill_addr"}, 32'(acc_addr[acc_cnt-1]), 32'(a));
        end
        @(negedge clock);
        check_status(tag);
    endtask

    initial begin
        int ack_wait;
        reset = 1'b0; req_valid = 1'b0; req_wren = 1'b0; req_addr = '0; req_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'($urandom);
        ram[5] = 8'h3C;
        model_reset();

        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_status("rst");
        reset = 1'b1;
        @(negedge clock);

        // Cold miss, second read hits, write hit then read back.
        run_txn("t1_cold_miss", 1'b0, 5'h05, 8'h00, 3);
        run_txn("t2_read_hit",  1'b0, 5'h05, 8'h00, 0);
        run_txn("t3_write_hit", 1'b1, 5'h05, 8'hA7, 0);
        run_txn("t3_read_back", 1'b0, 5'h05, 8'h00, 0);

        // Fill the rest, refresh 0x05, miss 0x09 evicts the clean 0x06 line.
        run_txn("t4_fill6", 1'b0, 5'h06, 8'h00, 1);
        run_txn("t4_fill7", 1'b0, 5'h07, 8'h00, 2);
        run_txn("t4_fill8", 1'b0, 5'h08, 8'h00, 0);
        run_txn("t4_touch5", 1'b0, 5'h05, 8'h00, 0);
        run_txn("t4_miss9", 1'b0, 5'h09, 8'h00, 1);

        // Dirty 0x07 with 0x11, make it oldest, then miss 0x1F.
        run_txn("t5_dirty7", 1'b1, 5'h07, 8'h11, 0);
        run_txn("t5_touch9", 1'b0, 5'h09, 8'h00, 0);
        run_txn("t5_touch5", 1'b0, 5'h05, 8'h00, 0);
        run_txn("t5_touch8", 1'b0, 5'h08, 8'h00, 0);
        run_txn("t5_wb_miss", 1'b0, 5'h1F, 8'h00, 2);

        // Reset while a fill is outstanding.
        req_valid = 1'b1; req_wren = 1'b0; req_addr = 5'h15;
        @(negedge clock);
        req_valid = 1'b0;
        ack_wait = 0;
        while (!mem_req && ack_wait < 20) begin
            @(negedge clock);
            ack_wait++;
        end
        check("t6_fill_started", 32'(mem_req && !mem_we), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_mem_req_drop", 32'(mem_req), 32'd0);
        model_reset();
        check_status("t6_in_reset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        @(negedge clock);
        mem_ack = 1'b0;
        check("t6_late_ack_ready", 32'(req_ready), 32'd1);
        check("t6_late_ack_req",   32'(mem_req),   32'd0);
        check_status("t6_late_ack");
        run_txn("t6_next_miss", 1'b0, 5'h05, 8'h00, 1);

        // Random traffic over a small address pool so hits, evictions and write-backs mix.
        for (int k = 0; k < 150; k++) begin
            logic [ADDR_W-1:0] ra;
            ra = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
            run_txn("rnd", 1'($urandom_range(0, 1)), ra, DATA_W'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound in case a wait ever misses its own limit.
    initial begin
        #2000000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
